// File: rtl/udc_host_sequencer.sv
// Host-side sequencer for an up/down counter peripheral: on each request it
// resets the counter, writes PLR/ULR/LLR/CCR, reads them back for
// verification, optionally starts a count and reports a 2-bit status.
module udc_host_sequencer #(
    parameter logic [15:0] TIMEOUT = 16'd4096
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_plr,
    input  logic [7:0] req_ulr,
    input  logic [7:0] req_llr,
    input  logic [7:0] req_ccr,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [1:0] rsp_status,
    output logic       udc_rst,
    output logic       ncs,
    output logic       nwr,
    output logic       nrd,
    output logic       a1,
    output logic       a0,
    output logic [7:0] udc_dout,
    output logic       udc_oe,
    input  logic [7:0] udc_din,
    output logic       start,
    input  logic       udc_err,
    input  logic       udc_ec
);

    typedef enum logic [2:0] {
        IDLE, RST, WR, RD, GAP, START, WAIT, RESP
    } state_t;

    localparam logic [1:0] ST_DONE     = 2'b00;
    localparam logic [1:0] ST_CNT_ERR  = 2'b01;
    localparam logic [1:0] ST_MISMATCH = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    state_t      state;
    logic [1:0]  idx;
    logic        mismatch;
    logic [15:0] timer;
    logic [7:0]  req_byte [4];

    wire accept = (state == IDLE) && req_valid && req_ready;

    // Capture the four register bytes when a request is accepted.
    // NOTE: this is pure data storage qualified by the FSM, so it carries no
    // reset; every byte is rewritten before it is ever driven or compared.
    always_ff @(posedge clk) begin
        if (accept) begin
            req_byte[0] <= req_plr;
            req_byte[1] <= req_ulr;
            req_byte[2] <= req_llr;
            req_byte[3] <= req_ccr;
        end
    end

    // Main sequencer: state, bus strobes and response, all registered.
    // NOTE: every sequential assignment is non-blocking so all outputs change
    // together on the edge and readers in the same cycle see old values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            idx        <= 2'd0;
            mismatch   <= 1'b0;
            timer      <= 16'd0;
            req_ready  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_status <= ST_DONE;
            udc_rst    <= 1'b1;
            ncs        <= 1'b1;
            nwr        <= 1'b1;
            nrd        <= 1'b1;
            {a1, a0}   <= 2'd0;
            udc_dout   <= 8'h00;
            udc_oe     <= 1'b0;
            start      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        req_ready <= 1'b0;
                        mismatch  <= 1'b0;
                        ncs       <= 1'b0;
                        udc_rst   <= 1'b1;
                        state     <= RST;
                    end
                end
                RST: begin
                    udc_rst  <= 1'b0;
                    nwr      <= 1'b0;
                    udc_oe   <= 1'b1;
                    idx      <= 2'd0;
                    {a1, a0} <= 2'd0;
                    udc_dout <= req_byte[0];
                    state    <= WR;
                end
                WR: begin
                    if (idx == 2'd3) begin
                        // Release the write strobe before asserting read so
                        // the two never overlap.
                        nwr      <= 1'b1;
                        udc_oe   <= 1'b0;
                        udc_dout <= 8'h00;
                        nrd      <= 1'b0;
                        idx      <= 2'd0;
                        {a1, a0} <= 2'd0;
                        state    <= RD;
                    end else begin
                        idx      <= idx + 2'd1;
                        {a1, a0} <= idx + 2'd1;
                        udc_dout <= req_byte[idx + 2'd1];
                    end
                end
                RD: begin
                    if (udc_din != req_byte[idx]) begin
                        mismatch <= 1'b1;
                    end
                    if (idx == 2'd3) begin
                        nrd   <= 1'b1;
                        state <= GAP;
                    end else begin
                        idx      <= idx + 2'd1;
                        {a1, a0} <= idx + 2'd1;
                    end
                end
                GAP: begin
                    if (mismatch || udc_err || (req_byte[3] == 8'h00)) begin
                        rsp_status <= mismatch ? ST_MISMATCH :
                                      udc_err  ? ST_CNT_ERR  : ST_DONE;
                        rsp_valid  <= 1'b1;
                        ncs        <= 1'b1;
                        state      <= RESP;
                    end else begin
                        start <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    start <= 1'b0;
                    timer <= 16'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + 16'd1;
                    // End-of-count wins over a simultaneous error flag.
                    if (udc_ec || udc_err || (timer == TIMEOUT - 16'd1)) begin
                        rsp_status <= udc_ec  ? ST_DONE    :
                                      udc_err ? ST_CNT_ERR : ST_TIMEOUT;
                        rsp_valid  <= 1'b1;
                        ncs        <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/udc_host_sequencer.md
UDC_HOST_SEQUENCER -- requirements
Module: udc_host_sequencer

Interface
REQ-001 Parameter TIMEOUT, 16'd4096, maximum WAIT-state cycles before timeout status.
REQ-002 clk  input  1  rising-edge clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, synchronous, active-low; clock clk.
REQ-004 req_valid  input  1  configuration request present.
REQ-005 req_ready  output  1  sequencer idle and able to accept a request.
REQ-006 req_plr, req_ulr, req_llr, req_ccr  input  8 each  preset, upper-limit, lower-limit and cycle-count values.
REQ-007 rsp_valid  output  1  result available; held until accepted.
REQ-008 rsp_ready  input  1  downstream accepts result.
REQ-009 rsp_status  output  2  00 done, 01 counter err, 10 readback mismatch, 11 timeout.
REQ-010 udc_rst  output  1  active-high reset to counter.
REQ-011 ncs, nwr, nrd  output  1 each  active-low counter bus strobes.
REQ-012 a1, a0  output  1 each  register select: 00 PLR, 01 ULR, 10 LLR, 11 CCR.
REQ-013 udc_dout  output  8  write data; udc_oe output 1 drive enable, high only when nwr=0.
REQ-014 udc_din  input  8  counter read data.
REQ-015 start  output  1  one-cycle count start pulse.
REQ-016 udc_err, udc_ec  input  1 each  counter error and end-of-count flags.

Function
REQ-017 States SHALL be IDLE, RST, WR, RD, GAP, START, WAIT, RESP; a 2-bit index steps WR and RD through addresses 00,01,10,11.
REQ-018 IDLE: req_ready=1, ncs=1; on req_valid&&req_ready, latch all four request bytes and go to RST.
REQ-019 RST (1 cycle): ncs=0, udc_rst=1, nwr=1, nrd=1, start=0.
REQ-020 WR (4 cycles): udc_rst=0, ncs=0, nwr=0, nrd=1, udc_oe=1, {a1,a0}=index, udc_dout = latched byte for that index.
REQ-021 RD (4 cycles): nwr=1, nrd=0, udc_oe=0, {a1,a0}=index; udc_din sampled at the closing edge of each cycle, compared with the latched byte, any difference sets a sticky mismatch flag.
REQ-022 GAP (1 cycle): nrd=1, ncs=0; at its closing edge: mismatch -> RESP status 10; else udc_err=1 -> RESP status 01; else ccr==0 -> RESP status 00 without a start pulse; else START.
REQ-023 START (1 cycle): start=1; then WAIT with start=0.
REQ-024 WAIT: 16-bit timer cleared on entry, incremented each cycle; udc_ec=1 -> status 00; else udc_err=1 -> status 01; else timer==TIMEOUT-1 -> status 11; simultaneous ec and err SHALL report 00.
REQ-025 Cycle timing: accept at edge 0; RST cycle 1; WR cycles 2-5; RD cycles 6-9; GAP cycle 10; start high cycle 11; WAIT from cycle 12.
REQ-026 RESP: rsp_valid=1 with stable rsp_status, ncs=1, strobes inactive; on rsp_ready go to IDLE; rsp_valid and req_ready never high together.
REQ-027 ncs=0 from RST through WAIT inclusive; nwr and nrd never low in the same cycle.
REQ-028 req_valid is ignored outside IDLE; request fields may change after acceptance without effect.

Reset
REQ-029 While reset=0 at a rising edge: state IDLE, req_ready=0, rsp_valid=0, rsp_status=00, udc_rst=1, ncs=1, nwr=1, nrd=1, a1=a0=0, udc_dout=0, udc_oe=0, start=0, mismatch=0, timer=0.
REQ-030 Reset asserted mid-sequence SHALL abort at the next edge with no response issued; req_ready=1 the first cycle after reset returns high.

Verification
REQ-031 Request PLR=5, ULR=15, LLR=1, CCR=1, model counter ends with ec -> bus writes 05,0F,01,01 at cycles 2-5, start at cycle 11, rsp_status=00.
REQ-032 Request PLR=20, ULR=10, LLR=1, CCR=2, counter raises err -> no start pulse, rsp_status=01.
REQ-033 Counter model returns 0x0E on ULR readback for ULR=0x0F -> no start pulse, rsp_status=10.
REQ-034 TIMEOUT=16, ec never asserted -> rsp_status=11 exactly 16 cycles after WAIT entry.
REQ-035 CCR=0, PLR=ULR=LLR=9 -> no start pulse, rsp_status=00 at GAP exit.
REQ-036 reset=0 during WR cycle 3 -> next edge all outputs at REQ-029 values, no rsp_valid; new request after reset completes normally.
